// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller, main memory model and their benches:
// word width, default geometry/latency, FSM state encoding and request op.
package cache_pkg;

    localparam int WORD_W             = 32;
    localparam int DEFAULT_LATENCY    = 4;
    localparam int DEFAULT_DEPTH_LOG2 = 10;
    localparam int LAT_CNT_W          = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_WAIT = 3'b010,
        S_RESP = 3'b100
    } mem_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_e;

    // Value loaded into the latency down-counter when a request is accepted.
    function automatic logic [LAT_CNT_W-1:0] lat_load(int latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/main_memory_if.sv
// Request/response bus between the cache controller (master) and main memory (slave).
// Handshake: a request (rd_mem/wr_mem) is taken on a rising edge only while busy_mem=0;
// busy_mem then stays high for the access latency, and request inputs are ignored until it drops.
interface main_memory_if;
    import cache_pkg::*;

    logic              rd_mem;
    logic              wr_mem;
    logic [WORD_W-1:0] addr_mem;
    logic [WORD_W-1:0] data_wr_mem;
    logic [WORD_W-1:0] data_rd_mem;
    logic              busy_mem;
    logic [31:0]       mem_rd_count;
    logic [31:0]       mem_wr_count;
    logic [31:0]       mem_conflict_count;

    modport master (
        output rd_mem, wr_mem, addr_mem, data_wr_mem,
        input  data_rd_mem, busy_mem, mem_rd_count, mem_wr_count, mem_conflict_count
    );

    modport slave (
        input  rd_mem, wr_mem, addr_mem, data_wr_mem,
        output data_rd_mem, busy_mem, mem_rd_count, mem_wr_count, mem_conflict_count
    );

endinterface

// File: rtl/main_memory_mem_array.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x WORD_W, registered read, no reset.
module mem_array
    import cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     din,
    output logic [WORD_W-1:0]     dout
);

    logic [WORD_W-1:0] ram [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= din;
        end
        dout <= ram[addr];
    end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency word-addressed main memory: serializes one request at a time, holds
// busy_mem for LATENCY cycles, then commits the write or presents the read word.
module main_memory
    import cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    main_memory_if.slave       mem,
    output mem_state_e         state_o
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_load(LATENCY);

    mem_state_e              state_q, state_d;
    logic [LAT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    mem_op_e                 op_q, op_d;
    logic                    busy_q, busy_d;
    logic [WORD_W-1:0]       data_rd_q, data_rd_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]             wr_cnt_q, wr_cnt_d;
    logic [31:0]             cf_cnt_q, cf_cnt_d;

    logic                    accept;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [WORD_W-1:0]       ram_dout;
    logic                    unused_addr_bits;

    assign req_idx          = mem.addr_mem[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{mem.addr_mem[WORD_W-1:DEPTH_LOG2+2], mem.addr_mem[1:0]};
    assign accept           = (mem.rd_mem | mem.wr_mem) && !busy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        data_rd_d = data_rd_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        cf_cnt_d  = cf_cnt_q;
        ram_we    = 1'b0;
        ram_addr  = idx_q;

        case (state_q)
            S_IDLE: begin
                // Read the incoming index straight away so the word is ready even at LATENCY=1.
                ram_addr = req_idx;
                if (accept) begin
                    idx_d   = req_idx;
                    wdata_d = mem.data_wr_mem;
                    op_d    = mem.wr_mem ? OP_WR : OP_RD;
                    cnt_d   = LAT_INIT;
                    if (mem.rd_mem && mem.wr_mem) begin
                        cf_cnt_d = cf_cnt_q + 32'd1;
                    end
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (cnt_q <= LAT_CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (op_q == OP_WR) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                end else begin
                    data_rd_d = ram_dout;
                    rd_cnt_d  = rd_cnt_q + 32'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            op_q      <= OP_RD;
            busy_q    <= 1'b0;
            data_rd_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            cf_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            data_rd_q <= data_rd_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            cf_cnt_q  <= cf_cnt_d;
        end
    end

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign mem.busy_mem           = busy_q;
    assign mem.data_rd_mem        = data_rd_q;
    assign mem.mem_rd_count       = rd_cnt_q;
    assign mem.mem_wr_count       = wr_cnt_q;
    assign mem.mem_conflict_count = cf_cnt_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: one instance at LATENCY=4, one at LATENCY=1, directed accesses
// with expected responses queued by the driver and checked by a negedge monitor.
module tb_main_memory;
    import cache_pkg::*;

    typedef struct packed {
        logic        is_rd;
        logic        chk_data;
        logic [31:0] data;
        logic [31:0] rd_cnt;
        logic [31:0] wr_cnt;
        logic [31:0] cf_cnt;
        logic [3:0]  gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    main_memory_if m4 ();
    main_memory_if m1 ();
    mem_state_e st4, st1;

    main_memory #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .mem(m4.slave), .state_o(st4)
    );
    main_memory #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem(m1.slave), .state_o(st1)
    );

    int n_vec = 0;
    int n_err = 0;

    exp_t        q4[$];
    exp_t        q1[$];
    logic [31:0] model [int];
    int          rd_c [2];
    int          wr_c [2];
    int          cf_c [2];

    logic        mon_prev [2];
    int          mon_hi   [2];
    int          mon_last [2];
    int          cyc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(int sel, logic rd, logic wr, logic [31:0] addr, logic [31:0] data);
        if (sel == 0) begin
            m4.rd_mem = rd; m4.wr_mem = wr; m4.addr_mem = addr; m4.data_wr_mem = data;
        end else begin
            m1.rd_mem = rd; m1.wr_mem = wr; m1.addr_mem = addr; m1.data_wr_mem = data;
        end
    endtask

    function automatic logic busy_of(int sel);
        return (sel == 0) ? m4.busy_mem : m1.busy_mem;
    endfunction

    task automatic wait_idle(int sel);
        int n = 0;
        while (busy_of(sel) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: dut%0d busy_mem still 1 after %0d cycles", sel, n);
        end
    endtask

    // Issue one single-cycle request and queue the response the memory must give for it.
    task automatic access(int sel, logic rd, logic wr, logic [31:0] addr, logic [31:0] data,
                          logic [3:0] gap);
        exp_t e;
        int   key;
        wait_idle(sel);
        key = sel * 4096 + int'(addr[11:2]);
        if (wr) begin
            model[key] = data;
            wr_c[sel]++;
            if (rd) cf_c[sel]++;
        end else begin
            rd_c[sel]++;
        end
        e.is_rd    = !wr;
        e.chk_data = !wr && model.exists(key);
        e.data     = model.exists(key) ? model[key] : 32'h0;
        e.rd_cnt   = 32'(rd_c[sel]);
        e.wr_cnt   = 32'(wr_c[sel]);
        e.cf_cnt   = 32'(cf_c[sel]);
        e.gap      = gap;
        if (sel == 0) q4.push_back(e);
        else          q1.push_back(e);
        set_req(sel, rd, wr, addr, data);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic mon(int sel);
        exp_t        e;
        logic        busy;
        logic [31:0] d, rc, wc, cc;
        busy = busy_of(sel);
        d  = (sel == 0) ? m4.data_rd_mem        : m1.data_rd_mem;
        rc = (sel == 0) ? m4.mem_rd_count       : m1.mem_rd_count;
        wc = (sel == 0) ? m4.mem_wr_count       : m1.mem_wr_count;
        cc = (sel == 0) ? m4.mem_conflict_count : m1.mem_conflict_count;
        if (!rst) begin
            mon_prev[sel] = 1'b0;
            mon_hi[sel]   = 0;
            return;
        end
        if (busy) mon_hi[sel]++;
        if (mon_prev[sel] && !busy) begin
            if ((sel == 0 && q4.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: dut%0d completed an access with none pending", sel);
            end else begin
                e = (sel == 0) ? q4.pop_front() : q1.pop_front();
                check($sformatf("busy_cycles_dut%0d", sel), 32'(mon_hi[sel]), (sel == 0) ? 32'd4 : 32'd1);
                if (e.chk_data) check($sformatf("rd_data_dut%0d", sel), d, e.data);
                check($sformatf("rd_count_dut%0d", sel), rc, e.rd_cnt);
                check($sformatf("wr_count_dut%0d", sel), wc, e.wr_cnt);
                check($sformatf("conflict_count_dut%0d", sel), cc, e.cf_cnt);
                if (e.gap != 0) check($sformatf("resp_gap_dut%0d", sel), 32'(cyc - mon_last[sel]), 32'(e.gap));
            end
            mon_last[sel] = cyc;
            mon_hi[sel]   = 0;
        end
        mon_prev[sel] = busy;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0);
        mon(1);
    end

    task automatic check_reset_state(int sel);
        if (sel == 0) begin
            check("rst_busy_dut0", {31'h0, m4.busy_mem}, 32'h0);
            check("rst_data_dut0", m4.data_rd_mem, 32'h0);
            check("rst_rdcnt_dut0", m4.mem_rd_count, 32'h0);
            check("rst_wrcnt_dut0", m4.mem_wr_count, 32'h0);
            check("rst_cfcnt_dut0", m4.mem_conflict_count, 32'h0);
            check("rst_state_dut0", {29'h0, st4}, {29'h0, 3'b001});
        end else begin
            check("rst_busy_dut1", {31'h0, m1.busy_mem}, 32'h0);
            check("rst_data_dut1", m1.data_rd_mem, 32'h0);
            check("rst_rdcnt_dut1", m1.mem_rd_count, 32'h0);
            check("rst_state_dut1", {29'h0, st1}, {29'h0, 3'b001});
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rd_c[s] = 0; wr_c[s] = 0; cf_c[s] = 0;
            mon_prev[s] = 1'b0; mon_hi[s] = 0; mon_last[s] = 0;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst = 1'b1;
        @(negedge clk);

        // Write then read back at LATENCY=4.
        access(0, 1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'd0);
        access(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'd0);

        // Aliasing modulo 1K words, and byte offset ignored.
        access(0, 1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, 4'd0);
        access(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'd0);
        access(0, 1'b1, 1'b0, 32'h0000_0007, 32'h0, 4'd0);

        // Conflict resolves to a write; a read pulsed while busy must be dropped.
        access(0, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'd0);
        set_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'd0);

        // Reset in the middle of a write: old word survives, counters clear.
        access(0, 1'b0, 1'b1, 32'h0000_0080, 32'h1111_1111, 4'd0);
        wait_idle(0);
        set_req(0, 1'b0, 1'b1, 32'h0000_0080, 32'h2222_2222);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("busy_async_clear", {31'h0, m4.busy_mem}, 32'h0);
        repeat (2) @(negedge clk);
        check_reset_state(0);
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rd_c[s] = 0; wr_c[s] = 0; cf_c[s] = 0;
        end
        @(negedge clk);
        access(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'd0);

        // LATENCY=1 burst: preload four words, then back-to-back reads two cycles apart.
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b0, 1'b1, 32'h0000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'd0);
        end
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b1, 1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0, (i == 0) ? 4'd0 : 4'd2);
        end

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("q_dut0_drained", 32'(q4.size()), 32'h0);
        check("q_dut1_drained", 32'(q1.size()), 32'h0);
        check("final_rdcnt_dut1", m1.mem_rd_count, 32'd4);
        check("final_wrcnt_dut0", m4.mem_wr_count, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main_memory.md
# main_memory

Word-addressed main-memory model with fixed access latency that sits directly downstream of the cache controller and serves its refill (read) and evict (write-back) word requests. It accepts one 32-bit request at a time over the `rd_mem`/`wr_mem`/`busy_mem` handshake, holds `busy_mem` high for a programmable number of cycles, then commits the write or presents the read word. It also keeps read/write/conflict statistics for the cache testbench.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words; storage is 2^DEPTH_LOG2 words.
- `LATENCY`, default 4: cycles `busy_mem` stays high per access; legal range 1..15.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_mem` in 1: read request.
- `wr_mem` in 1: write request.
- `addr_mem` in 32: byte address; word index = `addr_mem[DEPTH_LOG2+1:2]`.
- `data_wr_mem` in 32: write data.
- `data_rd_mem` out 32: read data, held until the next read completes.
- `busy_mem` out 1: access in progress; requests are ignored while high.
- `mem_rd_count` out 32: completed reads.
- `mem_wr_count` out 32: completed writes.
- `mem_conflict_count` out 32: requests accepted with both `rd_mem` and `wr_mem` high.

## Operation
- **Reset (`rst`=0):**
  - `busy_mem`=0, `data_rd_mem`=0, all counters 0, FSM=IDLE.
  - Latched request registers are cleared.
  - Array contents are not reset and survive reset.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - Acceptance at an edge requires `(rd_mem|wr_mem) && !busy_mem`.
  - On acceptance, latch the word index, write data and op, load the down-counter with `LATENCY-1`, and go to WAIT. If `LATENCY`=1, go straight to RESP.
- **Op selection:**
  - If both `rd_mem` and `wr_mem` are high, the write wins and `mem_conflict_count` increments once.
  - A read with `wr_mem` low is a read.
- **WAIT:** decrement each cycle; at 0, go to RESP.
- **RESP (one cycle):**
  - Write: array[idx] <= latched data; `mem_wr_count`+1.
  - Read: `data_rd_mem` <= array[idx]; `mem_rd_count`+1.
  - Return to IDLE.
- **Addressing:**
  - `addr_mem[1:0]` is ignored.
  - Address bits above `DEPTH_LOG2+1` are ignored, so addresses alias modulo the storage size.
- **Ordering:** requests are fully serialized, so a read following a write to the same word returns the new data.
- **Counters:** wrap modulo 2^32.
- **Reset mid-access:** the pending access is dropped, with no array update and no count. `busy_mem` goes to 0 asynchronously.
- **Request inputs during busy:** changes to the request inputs while `busy_mem`=1 have no effect.

## Timing
- Request sampled at edge T0: `busy_mem` is 1 after T0 and stays 1 through edge T0+LATENCY, exactly `LATENCY` cycles high.
- At edge T0+LATENCY:
  - `busy_mem` falls.
  - `data_rd_mem` updates (read) or the array commits (write).
  - The counter updates.
- Next request: earliest acceptance at edge T0+LATENCY+1. Sustained throughput is one access per `LATENCY`+1 cycles.
- A request held high continuously is accepted again at T0+LATENCY+1, so a requester must deassert to avoid a duplicate access.
- `busy_mem` and `data_rd_mem` are registered outputs; there is no combinational path from the inputs.

## Structure
- **Shared package `cache_pkg`:**
  - FSM state constants (IDLE/WAIT/RESP, one-hot, 3 bits).
  - Word width 32.
  - Default `LATENCY`.
  - `DEPTH_LOG2`.
  - These are shared with the cache controller and its bench.
- **Sub-module `mem_array`:**
  - Single-port synchronous RAM, 2^DEPTH_LOG2 x 32, with `we`/`addr`/`din`/`dout`.
  - Registered read, no reset.
  - `main_memory` wraps it with the FSM, latency counter and statistics.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release. Expect `busy_mem`=0, `data_rd_mem`=0 and all counts 0.
- **Write then read, `LATENCY`=4:**
  - `wr_mem` for one cycle with addr 0x0000_0104, data 0xDEADBEEF. Expect `busy_mem` high exactly 4 cycles.
  - Then `rd_mem` at the same address. Expect `data_rd_mem`=0xDEADBEEF on the edge `busy_mem` falls, with `mem_wr_count`=1 and `mem_rd_count`=1.
- **Aliasing:**
  - Write 0x1234_5678 to 0x0000_1004 (`DEPTH_LOG2`=10), then read 0x0000_0004. Expect 0x1234_5678.
  - Read 0x0000_0007. Expect the same word.
- **Conflict and ignored request:**
  - Assert `rd_mem`+`wr_mem` with data 0xA5A5A5A5 at 0x20. Expect a write and `mem_conflict_count`=1.
  - Pulse `rd_mem` to 0x40 while `busy_mem`=1. Expect the request ignored and `mem_rd_count` unchanged.
- **Reset mid-access:**
  - Write 0x1111_1111 to 0x80 and let it complete.
  - Start a write of 0x2222_2222 to 0x80 and assert `rst` low in the 2nd busy cycle. Expect `busy_mem`=0 immediately.
  - After release, a read of 0x80 returns 0x1111_1111 and `mem_wr_count`=0.
- **Cache burst (`LATENCY`=1):**
  - 4 back-to-back single-cycle reads at 0x100, 0x104, 0x108, 0x10C, each issued when `busy_mem`=0. Expect 4 responses spaced 2 cycles apart and `mem_rd_count`=4.
